dispatch_unit: RTL and testbench

DISPATCH_UNIT -- requirements
Module: dispatch_unit

---
 rtl/dispatch_unit.sv | 169 ++++++++++++++++
 tb/tb_dispatch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_unit.sv
// dispatch_unit: in-order dispatch queue that allocates ROB tags, LSQ ids and RS slots, up to WIDTH uops per cycle.
// Optional feature macro DISPATCH_RS_BYPASS_EN: uops flagged no_rs skip the RS and do not consume rs_free.
module dispatch_unit #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned LSQ_SIZE = 8,
  parameter int unsigned RS_SIZE  = 8,
  parameter int unsigned UOP_W    = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [UOP_W-1:0]                    in_uop,
  input  logic                                in_is_mem,
  input  logic                                in_no_rs,
  input  logic [$clog2(WIDTH+1)-1:0]          rob_retire,
  input  logic [$clog2(WIDTH+1)-1:0]          lsq_retire,
  input  logic [$clog2(RS_SIZE+1)-1:0]        rs_free,
  input  logic                                flush,
  output logic [WIDTH-1:0]                    disp_valid,
  output logic [WIDTH*UOP_W-1:0]              disp_uop,
  output logic [WIDTH*$clog2(ROB_SIZE+1)-1:0] disp_rob_tag,
  output logic [WIDTH*$clog2(LSQ_SIZE+1)-1:0] disp_lsq_id,
  output logic [WIDTH-1:0]                    disp_rs_req,
  output logic [$clog2(ROB_SIZE+1)-1:0]       rob_count,
  output logic [$clog2(LSQ_SIZE+1)-1:0]       lsq_count,
  output logic                                rob_full,
  output logic                                lsq_full
);
  localparam int unsigned TAG_W  = $clog2(ROB_SIZE+1);
  localparam int unsigned LID_W  = $clog2(LSQ_SIZE+1);
  localparam int unsigned QPTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned QCNT_W = $clog2(QDEPTH+1);

  logic [UOP_W-1:0]  r_q_uop [QDEPTH];
  logic [QDEPTH-1:0] r_q_mem;
  logic [QPTR_W-1:0] r_q_head;
  logic [QPTR_W-1:0] r_q_wptr;
  logic [QCNT_W-1:0] r_q_count;
  logic [TAG_W-1:0]  r_rob_count;
  logic [TAG_W-1:0]  r_rob_tail;
  logic [LID_W-1:0]  r_lsq_count;
  logic [LID_W-1:0]  r_lsq_tail;
  logic              r_rob_full;
  logic              r_lsq_full;

  logic              w_push;
  int                w_n_disp;
  int                w_n_mem;
  logic [TAG_W-1:0]  w_rob_count_nxt;
  logic [LID_W-1:0]  w_lsq_count_nxt;

`ifdef DISPATCH_RS_BYPASS_EN
  logic [QDEPTH-1:0] r_q_no_rs;

  always_ff @(posedge clk) begin
    if (w_push) r_q_no_rs[r_q_wptr] <= in_no_rs;
  end
`else
  logic w_unused_no_rs;
  assign w_unused_no_rs = in_no_rs;
`endif

  assign in_ready        = (int'(r_q_count) < int'(QDEPTH)) && !flush;
  assign w_push          = in_valid && in_ready;
  assign w_rob_count_nxt = TAG_W'(int'(r_rob_count) + w_n_disp - int'(rob_retire));
  assign w_lsq_count_nxt = LID_W'(int'(r_lsq_count) + w_n_mem - int'(lsq_retire));

  // Walk from the queue head in order; the first slot lacking an entry, ROB, LSQ or RS room ends dispatch.
  always_comb begin
    int                w_lsq_need;
    int                w_rs_need;
    int                w_slot_rs;
    logic              w_stop;
    logic [QPTR_W-1:0] w_idx;
    disp_valid   = '0;
    disp_uop     = '0;
    disp_rob_tag = '0;
    disp_lsq_id  = '0;
    disp_rs_req  = '0;
    w_n_disp     = 0;
    w_n_mem      = 0;
    w_lsq_need   = 0;
    w_rs_need    = 0;
    w_slot_rs    = 0;
    w_stop       = flush;
    w_idx        = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      w_idx = QPTR_W'((int'(r_q_head) + k) % int'(QDEPTH));
`ifdef DISPATCH_RS_BYPASS_EN
      w_slot_rs = r_q_no_rs[w_idx] ? 0 : 1;
`else
      w_slot_rs = 1;
`endif
      disp_rob_tag[k*TAG_W +: TAG_W] = TAG_W'(((int'(r_rob_tail) - 1 + k) % int'(ROB_SIZE)) + 1);
      if (!w_stop && (k < int'(r_q_count))
          && (int'(r_rob_count) + k + 1 <= int'(ROB_SIZE))
          && (w_lsq_need + int'(r_q_mem[w_idx]) <= int'(LSQ_SIZE) - int'(r_lsq_count))
          && (w_rs_need + w_slot_rs <= int'(rs_free))) begin
        disp_valid[k]                 = 1'b1;
        disp_uop[k*UOP_W +: UOP_W]    = r_q_uop[w_idx];
        disp_rs_req[k]                = (w_slot_rs != 0);
        if (r_q_mem[w_idx]) begin
          disp_lsq_id[k*LID_W +: LID_W] = LID_W'(((int'(r_lsq_tail) - 1 + w_lsq_need) % int'(LSQ_SIZE)) + 1);
          w_lsq_need = w_lsq_need + 1;
        end
        w_rs_need = w_rs_need + w_slot_rs;
        w_n_disp  = w_n_disp + 1;
      end else begin
        w_stop = 1'b1;
      end
    end
    w_n_mem = w_lsq_need;
  end

  // Payload storage needs no reset: r_q_count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_uop[r_q_wptr] <= in_uop;
      r_q_mem[r_q_wptr] <= in_is_mem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_head    <= '0;
      r_q_wptr    <= '0;
      r_q_count   <= '0;
      r_rob_count <= '0;
      r_lsq_count <= '0;
      r_rob_tail  <= TAG_W'(1);
      r_lsq_tail  <= LID_W'(1);
      r_rob_full  <= 1'b0;
      r_lsq_full  <= 1'b0;
    end else if (flush) begin
      r_q_head    <= '0;
      r_q_wptr    <= '0;
      r_q_count   <= '0;
      r_rob_count <= '0;
      r_lsq_count <= '0;
      r_rob_tail  <= TAG_W'(1);
      r_lsq_tail  <= LID_W'(1);
      r_rob_full  <= 1'b0;
      r_lsq_full  <= 1'b0;
    end else begin
      r_q_head    <= QPTR_W'((int'(r_q_head) + w_n_disp) % int'(QDEPTH));
      r_q_wptr    <= w_push ? QPTR_W'((int'(r_q_wptr) + 1) % int'(QDEPTH)) : r_q_wptr;
      r_q_count   <= QCNT_W'(int'(r_q_count) + int'(w_push) - w_n_disp);
      r_rob_count <= w_rob_count_nxt;
      r_lsq_count <= w_lsq_count_nxt;
      r_rob_tail  <= TAG_W'(((int'(r_rob_tail) - 1 + w_n_disp) % int'(ROB_SIZE)) + 1);
      r_lsq_tail  <= LID_W'(((int'(r_lsq_tail) - 1 + w_n_mem) % int'(LSQ_SIZE)) + 1);
      r_rob_full  <= (int'(w_rob_count_nxt) == int'(ROB_SIZE));
      r_lsq_full  <= (int'(w_lsq_count_nxt) == int'(LSQ_SIZE));
    end
  end

  assign rob_count = r_rob_count;
  assign lsq_count = r_lsq_count;
  assign rob_full  = r_rob_full;
  assign lsq_full  = r_lsq_full;

  // Retiring more than is allocated means upstream bookkeeping is broken.
  a_rob_retire: assert property (@(posedge clk) disable iff (reset) int'(rob_retire) <= int'(r_rob_count));
  a_lsq_retire: assert property (@(posedge clk) disable iff (reset) int'(lsq_retire) <= int'(r_lsq_count));

endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed and random stimulus for dispatch_unit, checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_dispatch_unit;
  localparam int WIDTH = 2, QDEPTH = 4, ROB = 16, LSQ = 8, RSS = 8, UOP_W = 64;
  localparam int RET_W = $clog2(WIDTH+1), RSF_W = $clog2(RSS+1);
  localparam int TAG_W = $clog2(ROB+1), LID_W = $clog2(LSQ+1);

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [UOP_W-1:0]         in_uop = '0;
  logic                     in_is_mem = 1'b0;
  logic                     in_no_rs = 1'b0;
  logic [RET_W-1:0]         rob_retire = '0;
  logic [RET_W-1:0]         lsq_retire = '0;
  logic [RSF_W-1:0]         rs_free = '0;
  logic                     flush = 1'b0;
  logic [WIDTH-1:0]         disp_valid;
  logic [WIDTH*UOP_W-1:0]   disp_uop;
  logic [WIDTH*TAG_W-1:0]   disp_rob_tag;
  logic [WIDTH*LID_W-1:0]   disp_lsq_id;
  logic [WIDTH-1:0]         disp_rs_req;
  logic [TAG_W-1:0]         rob_count;
  logic [LID_W-1:0]         lsq_count;
  logic                     rob_full;
  logic                     lsq_full;

  dispatch_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .in_is_mem(in_is_mem), .in_no_rs(in_no_rs), .rob_retire(rob_retire), .lsq_retire(lsq_retire),
    .rs_free(rs_free), .flush(flush), .disp_valid(disp_valid), .disp_uop(disp_uop),
    .disp_rob_tag(disp_rob_tag), .disp_lsq_id(disp_lsq_id), .disp_rs_req(disp_rs_req),
    .rob_count(rob_count), .lsq_count(lsq_count), .rob_full(rob_full), .lsq_full(lsq_full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] uop; bit mem; bit nors; } ent_t;
  ent_t mq[$];
  int   m_rob, m_lsq, m_rtail, m_ltail;
  int   n_cmp = 0, n_bad = 0;

  bit [WIDTH-1:0] e_valid, e_rsreq;
  int             e_tag [WIDTH];
  int             e_lid [WIDTH];
  int             e_n, e_nmem;

  logic [WIDTH-1:0] o_valid, o_rsreq;
  int               o_tag [WIDTH];
  int               o_lid [WIDTH];
  int               o_robc, o_lsqc;
  logic             o_ready, o_robf, o_lsqf;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rs_need(input ent_t e);
`ifdef DISPATCH_RS_BYPASS_EN
    return e.nors ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  // What must dispatch this cycle, from the queue contents and current resource counts.
  function automatic void model_expect();
    int lsq_d, rs_d, nr;
    bit stop;
    lsq_d = 0; rs_d = 0; stop = flush;
    e_valid = '0; e_rsreq = '0; e_n = 0; e_nmem = 0;
    for (int k = 0; k < WIDTH; k++) begin
      e_tag[k] = 0; e_lid[k] = 0;
      if (!stop) begin
        if (k >= mq.size()) stop = 1;
        else begin
          nr = rs_need(mq[k]);
          if (m_rob + k + 1 > ROB || lsq_d + int'(mq[k].mem) > LSQ - m_lsq || rs_d + nr > int'(rs_free))
            stop = 1;
          else begin
            e_valid[k] = 1'b1;
            e_rsreq[k] = (nr == 1);
            e_tag[k]   = ((m_rtail - 1 + k) % ROB) + 1;
            if (mq[k].mem) begin
              e_lid[k] = ((m_ltail - 1 + lsq_d) % LSQ) + 1;
              lsq_d++;
            end
            rs_d += nr;
            e_n++;
          end
        end
      end
    end
    e_nmem = lsq_d;
  endfunction

  task automatic compare_all();
    model_expect();
    check("in_ready", 64'(in_ready), 64'(mq.size() < QDEPTH && !flush));
    check("disp_valid", 64'(disp_valid), 64'(e_valid));
    for (int k = 0; k < WIDTH; k++) begin
      if (e_valid[k] && disp_valid[k]) begin
        check("disp_uop", disp_uop[k*UOP_W +: UOP_W], mq[k].uop);
        check("disp_rob_tag", 64'(disp_rob_tag[k*TAG_W +: TAG_W]), 64'(e_tag[k]));
        check("disp_lsq_id", 64'(disp_lsq_id[k*LID_W +: LID_W]), 64'(e_lid[k]));
        check("disp_rs_req", 64'(disp_rs_req[k]), 64'(e_rsreq[k]));
      end
    end
    check("rob_count", 64'(rob_count), 64'(m_rob));
    check("lsq_count", 64'(lsq_count), 64'(m_lsq));
    check("rob_full", 64'(rob_full), 64'(m_rob == ROB));
    check("lsq_full", 64'(lsq_full), 64'(m_lsq == LSQ));
  endtask

  task automatic model_update();
    bit push;
    push = in_valid && (mq.size() < QDEPTH) && !flush;
    if (flush) begin
      mq.delete(); m_rob = 0; m_lsq = 0; m_rtail = 1; m_ltail = 1;
    end else begin
      for (int i = 0; i < e_n; i++) void'(mq.pop_front());
      m_rob   = m_rob + e_n - int'(rob_retire);
      m_lsq   = m_lsq + e_nmem - int'(lsq_retire);
      m_rtail = ((m_rtail - 1 + e_n) % ROB) + 1;
      m_ltail = ((m_ltail - 1 + e_nmem) % LSQ) + 1;
      if (push) mq.push_back('{in_uop, in_is_mem, in_no_rs});
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_rob = 0; m_lsq = 0; m_rtail = 1; m_ltail = 1;
  endtask

  // One clock cycle: drive, compare at negedge, advance the model at posedge.
  task automatic cyc(input bit v, input bit mem, input bit nors, input int rr, input int lr,
                     input int rsf, input bit fl);
    in_valid = v; in_uop = {$urandom, $urandom}; in_is_mem = mem; in_no_rs = nors;
    rob_retire = RET_W'(rr); lsq_retire = RET_W'(lr); rs_free = RSF_W'(rsf); flush = fl;
    @(negedge clk);
    compare_all();
    o_valid = disp_valid; o_rsreq = disp_rs_req; o_ready = in_ready;
    o_robc = int'(rob_count); o_lsqc = int'(lsq_count); o_robf = rob_full; o_lsqf = lsq_full;
    for (int k = 0; k < WIDTH; k++) begin
      o_tag[k] = int'(disp_rob_tag[k*TAG_W +: TAG_W]);
      o_lid[k] = int'(disp_lsq_id[k*LID_W +: LID_W]);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; rob_retire = 0; lsq_retire = 0; rs_free = 0;
    reset = 1'b1;
    #2;
    check("rst_disp_valid", 64'(disp_valid), 0);
    check("rst_rob_count", 64'(rob_count), 0);
    check("rst_lsq_count", 64'(lsq_count), 0);
    check("rst_rob_full", 64'(rob_full), 0);
    check("rst_lsq_full", 64'(lsq_full), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Push n uops through with ample RS so each dispatches the cycle after it is enqueued.
  task automatic fill(input int n, input bit mem);
    for (int i = 0; i < n; i++) cyc(1, mem, 0, 0, 0, 8, 0);
    cyc(0, 0, 0, 0, 0, 8, 0);
  endtask

  initial begin
    int rr, lr;
    #1;
    do_reset();

    // Two uops held back by rs_free=0, then released together.
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("ready_after_reset", 64'(o_ready), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("pair_valid", 64'(o_valid), 64'(2'b11));
    check("pair_tag0", 64'(o_tag[0]), 1);
    check("pair_tag1", 64'(o_tag[1]), 2);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("pair_rob_count", 64'(o_robc), 2);

    // ROB one short of full: only slot 0, then tag wraps to 1 after a retire.
    do_reset();
    fill(15, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("robwrap_valid", 64'(o_valid), 64'(2'b01));
    check("robwrap_tag16", 64'(o_tag[0]), 16);
    cyc(0, 0, 0, 1, 0, 8, 0);
    check("robwrap_full", 64'(o_robf), 1);
    check("robwrap_retire_same_cycle", 64'(o_valid), 0);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("robwrap_valid2", 64'(o_valid), 64'(2'b01));
    check("robwrap_tag1", 64'(o_tag[0]), 1);

    // LSQ full: ALU goes, LOAD waits a cycle for the retired entry.
    do_reset();
    fill(8, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 8, 0);
    check("lsq_alu_only", 64'(o_valid), 64'(2'b01));
    check("lsq_full_seen", 64'(o_lsqf), 1);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("lsq_load_valid", 64'(o_valid), 64'(2'b01));
    check("lsq_load_id", 64'(o_lid[0]), 1);
    check("lsq_count_after", 64'(o_lsqc), 7);

    // [LUI(no_rs), ADD] with rs_free=1, parked behind a full ROB first.
    do_reset();
    fill(16, 0);
    cyc(1, 0, 1, 0, 0, 8, 0);
    cyc(1, 0, 0, 0, 0, 8, 0);
    cyc(0, 0, 0, 2, 0, 1, 0);
    check("rs_blocked_by_rob", 64'(o_valid), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
`ifdef DISPATCH_RS_BYPASS_EN
    check("rs_bypass_valid", 64'(o_valid), 64'(2'b11));
    check("rs_bypass_req", 64'(o_rsreq), 64'(2'b10));  // slot 0 (LUI) needs no RS
`else
    check("rs_nobypass_valid", 64'(o_valid), 64'(2'b01));
    check("rs_nobypass_req", 64'(o_rsreq), 64'(2'b01));
`endif

    // Flush with three queued, rob_count=5, in_valid=1.
    do_reset();
    fill(5, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 8, 1);
    check("flush_valid", 64'(o_valid), 0);
    check("flush_ready", 64'(o_ready), 0);
    check("flush_rob_before", 64'(o_robc), 5);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("flush_rob_after", 64'(o_robc), 0);
    check("flush_queue_empty", 64'(o_valid), 0);
    cyc(1, 0, 0, 0, 0, 8, 0);
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("flush_first_tag", 64'(o_tag[0]), 1);
    check("flush_first_valid", 64'(o_valid), 64'(2'b01));

    // Asynchronous reset pulse between edges with two uops queued.
    do_reset();
    fill(3, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    in_valid = 0; rs_free = RSF_W'(8);
    #2;
    check("pre_pulse_valid", 64'(disp_valid), 64'(2'b11));
    check("pre_pulse_rob", 64'(rob_count), 3);
    reset = 1'b1;
    #1;
    check("pulse_valid", 64'(disp_valid), 0);
    check("pulse_rob", 64'(rob_count), 0);
    check("pulse_lsq", 64'(lsq_count), 0);
    check("pulse_robf", 64'(rob_full), 0);
    check("pulse_lsqf", 64'(lsq_full), 0);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 8, 0);
    check("pulse_queue_discarded", 64'(o_valid), 0);
    check("pulse_ready", 64'(o_ready), 1);

    // Random traffic; retires are kept within current occupancy.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, (m_rob < WIDTH) ? m_rob : WIDTH));
      lr = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, (m_lsq < WIDTH) ? m_lsq : WIDTH));
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 3) == 0,
          rr, lr, int'($urandom_range(0, RSS)), $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
